// File: rtl/vproc_pkg.sv
// Shared types for the vector processor result path.
// Slot payload record and FIFO pointer sizing used by the xreg result reorder stage.
package vproc_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        freg;
  } xreg_slot_t;

  // One extra MSB beyond the index lets full and empty be told apart.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vproc_id_fifo.sv
// Order FIFO of instruction IDs; head_o shows the oldest entry while not empty.
// Pushes while full and pops while empty are ignored.
module vproc_id_fifo
  import vproc_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk_i,
  input  logic              async_rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PW = fifo_ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]     wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/vproc_xreg_result_order.sv
// Reorders out-of-order scalar-register results from the vector pipelines into
// allocation order for the result arbiter; killed instructions retire silently.
module vproc_xreg_result_order
  import vproc_pkg::*;
#(
  parameter int unsigned XIF_ID_W       = 3,
  parameter int unsigned PIPE_CNT       = 2,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         async_rst_ni,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [XIF_ID_W-1:0]          alloc_id_i,
  input  logic [PIPE_CNT-1:0]          pipe_valid_i,
  output logic [PIPE_CNT-1:0]          pipe_ready_o,
  input  logic [PIPE_CNT*XIF_ID_W-1:0] pipe_id_i,
  input  logic [PIPE_CNT*5-1:0]        pipe_addr_i,
  input  logic [PIPE_CNT*32-1:0]       pipe_data_i,
  input  logic [PIPE_CNT-1:0]          pipe_freg_i,
  input  logic                         commit_valid_i,
  input  logic [XIF_ID_W-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         result_xreg_valid_o,
  input  logic                         result_xreg_ready_i,
  output logic [XIF_ID_W-1:0]          result_xreg_id_o,
  output logic [4:0]                   result_xreg_addr_o,
  output logic [31:0]                  result_xreg_data_o,
  output logic                         result_freg_o
);

  localparam int unsigned XIF_ID_CNT = 1 << XIF_ID_W;

  logic [XIF_ID_CNT-1:0] alloc_q, filled_q, killed_q;
  xreg_slot_t            slot_q [XIF_ID_CNT];

  logic                fifo_full, fifo_empty;
  logic [XIF_ID_W-1:0] head_id;
  logic                alloc_fire, head_valid, head_kill, pop;
  logic                commit_kill, kill_new, kill_old;

  vproc_id_fifo #(
    .DEPTH  (XIF_ID_CNT),
    .DATA_W (XIF_ID_W)
  ) i_id_fifo (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .push_i       (alloc_fire),
    .push_data_i  (alloc_id_i),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head_id)
  );

  assign alloc_ready_o = ~fifo_full;
  assign alloc_fire    = alloc_valid_i & ~fifo_full;

  assign head_valid = ~fifo_empty & filled_q[head_id] & ~killed_q[head_id];
  assign head_kill  = ~fifo_empty & killed_q[head_id];
  assign pop        = head_kill | (head_valid & result_xreg_ready_i);

  // A head already presented to the arbiter is never withdrawn, so kills of it are dropped.
  assign commit_kill = commit_valid_i & commit_kill_i;
  assign kill_new    = commit_kill & alloc_fire & (commit_id_i == alloc_id_i);
  assign kill_old    = commit_kill & alloc_q[commit_id_i] &
                       ~(head_valid & (commit_id_i == head_id));

  always_comb begin
    pipe_ready_o = '0;
    for (int p = 0; p < PIPE_CNT; p++) begin
      pipe_ready_o[p] = alloc_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]] &
                        ~filled_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]];
    end
  end

  // Later assignments win: kill, then slot release on pop, then a fresh allocation.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      alloc_q  <= '0;
      filled_q <= '0;
      killed_q <= '0;
      for (int i = 0; i < XIF_ID_CNT; i++) slot_q[i] <= '0;
    end else begin
      for (int p = 0; p < PIPE_CNT; p++) begin
        if (pipe_valid_i[p] && pipe_ready_o[p]) begin
          filled_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]]    <= 1'b1;
          slot_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]].addr <= pipe_addr_i[p*5 +: 5];
          slot_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]].data <= pipe_data_i[p*32 +: 32];
          slot_q[pipe_id_i[p*XIF_ID_W +: XIF_ID_W]].freg <= pipe_freg_i[p];
        end
      end
      if (kill_old) killed_q[commit_id_i] <= 1'b1;
      if (pop) begin
        alloc_q[head_id]  <= 1'b0;
        filled_q[head_id] <= 1'b0;
        killed_q[head_id] <= 1'b0;
      end
      if (alloc_fire) begin
        alloc_q[alloc_id_i]  <= 1'b1;
        filled_q[alloc_id_i] <= 1'b0;
        killed_q[alloc_id_i] <= kill_new;
      end
    end
  end

  assign result_xreg_valid_o = head_valid;
  assign result_xreg_id_o    = head_valid ? head_id : (DONT_CARE_ZERO ? '0 : 'x);
  assign result_xreg_addr_o  = head_valid ? slot_q[head_id].addr : (DONT_CARE_ZERO ? '0 : 'x);
  assign result_xreg_data_o  = head_valid ? slot_q[head_id].data : (DONT_CARE_ZERO ? '0 : 'x);
  assign result_freg_o       = head_valid & slot_q[head_id].freg;

  for (genvar p = 0; p < PIPE_CNT; p++) begin : g_dup_p
    for (genvar q = p + 1; q < PIPE_CNT; q++) begin : g_dup_q
      a_no_dup_id : assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        !(pipe_valid_i[p] && pipe_valid_i[q] &&
          (pipe_id_i[p*XIF_ID_W +: XIF_ID_W] == pipe_id_i[q*XIF_ID_W +: XIF_ID_W])));
    end
  end

endmodule

// File: doc/vproc_xreg_result_order.md
# vproc_xreg_result_order

Reorder stage directly upstream of the vector result arbiter's XREG port. Vector pipelines return scalar-register results (reductions, vmv.x.s, vfmv.f.s, vpopc, vfirst) out of order. This block stores each result in a per-ID slot and presents them to `result_xreg_*` strictly in allocation order. Instructions killed by the XIF commit interface are discarded without producing a result.

## Interface
- `XIF_ID_W`, 3: width of XIF instruction IDs; slot count `XIF_ID_CNT = 1 << XIF_ID_W`.
- `PIPE_CNT`, 2: number of producer pipelines writing results.
- `DONT_CARE_ZERO`, 1'b0: drive don't-care outputs to '0 instead of 'x.
- `clk_i` in 1: sole clock.
- `async_rst_ni` in 1: asynchronous active-low reset.
- `alloc_valid_i` in 1: decoder registers an issued instruction that will return an xreg result.
- `alloc_ready_o` out 1: order FIFO not full.
- `alloc_id_i` in XIF_ID_W: ID of the allocated instruction.
- `pipe_valid_i` in PIPE_CNT: per-pipe result valid.
- `pipe_ready_o` out PIPE_CNT: per-pipe result accepted.
- `pipe_id_i` in PIPE_CNT*XIF_ID_W: per-pipe result ID.
- `pipe_addr_i` in PIPE_CNT*5: per-pipe destination register.
- `pipe_data_i` in PIPE_CNT*32: per-pipe result data.
- `pipe_freg_i` in PIPE_CNT: destination is an FP register.
- `commit_valid_i` in 1: XIF commit valid.
- `commit_id_i` in XIF_ID_W: XIF commit ID.
- `commit_kill_i` in 1: XIF commit kill.
- `result_xreg_valid_o` out 1: head result valid, towards the result arbiter.
- `result_xreg_ready_i` in 1: arbiter accepts.
- `result_xreg_id_o` out XIF_ID_W: result ID.
- `result_xreg_addr_o` out 5: result destination register.
- `result_xreg_data_o` out 32: result data.
- `result_freg_o` out 1: result targets an FP register.

## Operation
- **State**
  - Order FIFO of XIF_ID_CNT IDs. Read/write pointers are XIF_ID_W+1 bits; the MSB disambiguates full from empty.
  - Per-ID slot: `alloc`, `filled`, `killed`, addr, data, freg.
- **Allocate**
  - Happens when `alloc_valid_i & alloc_ready_o`.
  - Pushes the ID into the FIFO, sets `alloc[id]`, and clears `filled`/`killed` for that ID.
  - `alloc_ready_o = ~full`. No bypass on a simultaneous pop.
- **Result write**
  - `pipe_ready_o[p] = alloc[pipe_id_i[p]] & ~filled[pipe_id_i[p]]`.
  - On handshake, set `filled` and latch addr/data/freg.
  - Two pipes presenting the same ID in one cycle is a protocol violation (SVA). Distinct IDs are written in parallel.
- **Kill**
  - `commit_valid_i & commit_kill_i` on an allocated ID sets `killed[id]`.
  - A non-kill commit has no effect.
  - Results for killed IDs are still accepted (ready follows the write rule) and discarded.
- **Head**
  - Let h = FIFO head ID.
    - If `killed[h]`: pop silently (one per cycle) and free the slot; `result_xreg_valid_o = 0` that cycle.
    - Else if `filled[h]`: `result_xreg_valid_o = 1`, outputs driven from slot h.
    - On `result_xreg_ready_i`: pop and free the slot.
- **Outputs**
  - When not valid: id/addr/data are 'x (or '0 if DONT_CARE_ZERO); `result_freg_o = 0`.
  - `result_freg_o = result_xreg_valid_o & freg[h]`.
- **Simultaneous events (same cycle, same ID)**
  - Kill + result: result accepted and then discarded.
  - Kill + alloc: kill applies to the new allocation.
  - Kill of the head while valid and ready is high: the pop is a normal result pop; the kill is ignored.

## Timing
- **Reset:** FIFO empty, all flags 0. Outputs: `result_xreg_valid_o = 0`, `alloc_ready_o = 1`, `pipe_ready_o = 0`, `result_freg_o = 0`.
- **Result latency:** a result written in cycle N to the head slot gives `result_xreg_valid_o` in cycle N+1. There is no combinational path from pipe inputs to the output.
- **Killed head:** retired in the cycle after the kill.
- **Output stability:** valid and all payload are driven from flops and stay stable until ready; valid never drops without a handshake, except on reset.
- **Throughput:** one result per cycle.
- **Pointer wrap-around:** modulo 2·XIF_ID_CNT.
- **Reset mid-operation:** all pending entries are discarded; outputs return to reset values asynchronously.

## Structure
- Slot record typedef and FIFO pointer width belong in the shared `vproc_pkg`.
- The order FIFO is a natural sub-module: `vproc_id_fifo`, with parameter `DEPTH` and push/pop/full/empty/head ports.
- Flag arrays and the arbitration logic live in the top module.

## Test plan
- Alloc IDs 2,3. Pipe1 writes ID 3 (data 0xBEEF); pipe0 writes ID 2 (data 0x1234) two cycles later → output ID 2/0x1234 then ID 3/0xBEEF, back to back.
- Fill all 8 IDs → `alloc_ready_o = 0`. Pop one with ready → `alloc_ready_o = 1` the next cycle; pointer wrap is verified.
- Alloc IDs 0,1. Kill ID 0. Result for ID 0 arrives, then ID 1 → only ID 1 is output, with no bubble beyond one cycle.
- Head valid with `result_xreg_ready_i = 0` for 5 cycles → id/addr/data/freg held constant; popped on the cycle ready rises.
- Pipe0 ID 4 and pipe1 ID 5 in the same cycle, with freg set on ID 5 → both accepted. ID 5 output with `result_freg_o = 1`.
- Assert `async_rst_ni` low mid-stream with 3 entries pending → all outputs at reset values immediately; no result emitted after release.
